// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives a combinational instruction
// memory, and fills the IF/ID register while handling stall, redirect, halt and faults.
module inst_fetch_ctrl #(
    parameter int unsigned MEM_BYTES = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      ImemAddr,
    input  logic [31:0]      ImemInst,
    input  logic             Stall,
    input  logic             Redirect,
    input  logic [31:0]      Target,
    input  logic             Halt,
    output logic [31:0]      IfIdInst,
    output logic [31:0]      IfIdPC,
    output logic             IfIdValid,
    output logic [31:0]      PCPlus4,
    output logic             Fault,
    output logic [31:0]      FaultAddr,
    output logic [CNT_W-1:0] FetchCnt,
    output logic [1:0]       State
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HALT  = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      ifpc_q, ifpc_d;
    logic             valid_q, valid_d;
    logic [31:0]      faddr_q, faddr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pc_legal;
    logic             target_legal;

    // The +3 is done in 33 bits so an address near 2^32 cannot wrap into range.
    function automatic logic addr_legal(input logic [31:0] addr);
        logic [32:0] last_byte;
        last_byte = {1'b0, addr} + 33'd3;
        return (addr[1:0] == 2'b00) && (last_byte < 33'(MEM_BYTES));
    endfunction

    assign pc_legal     = addr_legal(pc_q);
    assign target_legal = addr_legal(Target);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        faddr_d = faddr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (Redirect) begin
                    valid_d = 1'b0;
                    if (target_legal) begin
                        pc_d = Target;
                    end else begin
                        state_d = ST_FAULT;
                        faddr_d = Target;
                    end
                end else if (Halt) begin
                    state_d = ST_HALT;
                    valid_d = 1'b0;
                end else if (!Stall) begin
                    if (!pc_legal) begin
                        state_d = ST_FAULT;
                        faddr_d = pc_q;
                        valid_d = 1'b0;
                    end else begin
                        inst_d  = ImemInst;
                        ifpc_d  = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_HALT: begin
                valid_d = 1'b0;
                if (Redirect) begin
                    if (target_legal) begin
                        pc_d    = Target;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_FAULT;
                        faddr_d = Target;
                    end
                end
            end
            ST_FAULT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_RUN;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            inst_q  <= 32'd0;
            ifpc_q  <= 32'd0;
            valid_q <= 1'b0;
            faddr_q <= 32'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
            faddr_q <= faddr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ImemAddr  = pc_q;
    assign PCPlus4   = pc_q + 32'd4;
    assign IfIdInst  = inst_q;
    assign IfIdPC    = ifpc_q;
    assign IfIdValid = valid_q;
    assign Fault     = (state_q == ST_FAULT);
    assign FaultAddr = faddr_q;
    assign FetchCnt  = cnt_q;
    assign State     = state_q;

endmodule
